// File: rtl/seq_div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding and
// the iteration-counter width helper.
package seq_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter holds N-1 down to 0, so $clog2(N) bits suffice for N >= 2.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_div_rcs.sv
// Parameterised ripple-carry subtractor: d = x - y, built from full-adder
// cells with y inverted and carry-in tied high. bo=1 means the result is negative.
module rcs_ #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] d,
    output logic         bo
);

    logic [W:0]   c;
    logic [W-1:0] y_n;

    assign c[0] = 1'b1;
    assign y_n  = ~y;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign d[i]   = x[i] ^ y_n[i] ^ c[i];
        assign c[i+1] = (x[i] & y_n[i]) | (c[i] & (x[i] ^ y_n[i]));
    end

    // A missing final carry is a borrow out of the top bit.
    assign bo = ~c[W];

endmodule

// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// registered done pulse carrying q, r and the divide-by-zero flag.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);

    localparam int CW = cnt_width(N);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N:0]    pr_q, pr_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          done_q, done_d;

    logic [N:0]    trial;
    logic [N:0]    sub_d;
    logic          sub_bo;
    logic          pr_msb_unused;

    // The restored remainder is always below the divisor, so PR's top bit stays 0.
    assign pr_msb_unused = pr_q[N];
    assign trial         = {pr_q[N-1:0], dvd_q[N-1]};

    rcs_ #(.W(N + 1)) u_rcs (
        .x  (trial),
        .y  ({1'b0, dvs_q}),
        .d  (sub_d),
        .bo (sub_bo)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q marks the result cycle; a start there waits a cycle.
                if (start && !done_q) begin
                    dvd_d = a;
                    dvs_d = b;
                    if (b == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        pr_d    = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(N - 1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                pr_d  = sub_bo ? trial : sub_d;
                dvd_d = {dvd_q[N-2:0], 1'b0};
                quo_d = {quo_q[N-2:0], ~sub_bo};
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dvs_q == '0) begin
                    q_d  = '1;
                    r_d  = dvd_q;
                    dz_d = 1'b1;
                end else begin
                    q_d  = quo_q;
                    r_d  = pr_q[N-1:0];
                    dz_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed N=4 vector table, hand-written multi-cycle
// corner sequences, and an N=8 operand sweep against a / and % model.
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, dz4;
    logic [3:0] q4, r4;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, dz8;
    logic [7:0] q8, r8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
        int         busy;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    seq_div #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .q     (q4),
        .r     (r4),
        .dz    (dz4)
    );

    seq_div #(.N(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .q     (q8),
        .r     (r8),
        .dz    (dz8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; returns edges from acceptance to done (-1 on timeout).
    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int busy_cnt);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        tick();
        start4 = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            if (done4) begin
                lat = j;
                break;
            end
            if (busy4) busy_cnt++;
            tick();
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        tick();
        start8 = 1'b0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (done8) begin
                lat = j;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        logic [7:0] ra, rb;

        tbl[0] = '{4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 5, 4};
        tbl[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 4};
        tbl[2] = '{4'd5,  4'd7, 4'd0,  4'd5, 1'b0, 5, 4};
        tbl[3] = '{4'd0,  4'd3, 4'd0,  4'd0, 1'b0, 5, 4};
        tbl[4] = '{4'd9,  4'd0, 4'hF,  4'd9, 1'b1, 1, 0};
        tbl[5] = '{4'd12, 4'd5, 4'd2,  4'd2, 1'b0, 5, 4};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", busy4, 0);
        check("reset_done", done4, 0);
        check("reset_q", q4, 0);
        check("reset_r", r4, 0);
        check("reset_dz", dz4, 0);

        // rst and start together: reset must win.
        rst = 1'b1; start4 = 1'b1; a4 = 4'd5; b4 = 4'd1;
        tick();
        rst = 1'b0; start4 = 1'b0;
        check("rst_start_busy", busy4, 0);
        dcnt = 0;
        for (int j = 0; j < 8; j++) begin
            if (done4 || busy4) dcnt++;
            tick();
        end
        check("rst_start_no_op", dcnt, 0);

        for (int i = 0; i < 6; i++) begin
            run4(tbl[i].a, tbl[i].b, lat, bcnt);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_busy", i), bcnt, tbl[i].busy);
            check($sformatf("vec%0d_q", i), q4, tbl[i].q);
            check($sformatf("vec%0d_r", i), r4, tbl[i].r);
            check($sformatf("vec%0d_dz", i), dz4, tbl[i].dz);
            tick();
        end

        // Restart pulse and operand churn during RUN must be ignored.
        start4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd1;
        tick();
        start4 = 1'b0; a4 = 4'd9; b4 = 4'd5;
        check("midrun_q_hold", q4, 4'd2);
        check("midrun_r_hold", r4, 4'd2);
        lat = -1;
        for (int j = 3; j < 40; j++) begin
            if (done4) begin
                lat = j;
                break;
            end
            a4 = a4 + 4'd3;
            b4 = b4 ^ 4'd6;
            tick();
        end
        check("midrun_lat", lat, 5);
        check("midrun_q", q4, 4'd4);
        check("midrun_r", r4, 4'd2);
        for (int j = 0; j < 3; j++) begin
            a4 = 4'(j * 5);
            tick();
        end
        check("midrun_q_stable", q4, 4'd4);
        check("midrun_r_stable", r4, 4'd2);

        // Reset in the third RUN cycle aborts silently.
        start4 = 1'b1; a4 = 4'd11; b4 = 4'd2;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        check("abort_busy_before", busy4, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_q", q4, 0);
        check("abort_r", r4, 0);
        check("abort_dz", dz4, 0);
        run4(4'd7, 4'd2, lat, bcnt);
        check("post_abort_lat", lat, 5);
        check("post_abort_q", q4, 4'd3);
        check("post_abort_r", r4, 4'd1);
        tick();

        // N=8 sweep with edge operands first, then random pairs.
        for (int i = 0; i < 1000; i++) begin
            case (i)
                0: begin ra = 8'd255; rb = 8'd1;   end
                1: begin ra = 8'd255; rb = 8'd255; end
                2: begin ra = 8'd0;   rb = 8'd1;   end
                3: begin ra = 8'd1;   rb = 8'd255; end
                4: begin ra = 8'd128; rb = 8'd127; end
                default: begin
                    ra = 8'($urandom_range(255, 0));
                    rb = 8'($urandom_range(255, 1));
                end
            endcase
            run8(ra, rb, lat);
            check($sformatf("sweep%0d_lat", i), lat, 9);
            check($sformatf("sweep%0d_q_%0d_%0d", i, ra, rb), q8, ra / rb);
            check($sformatf("sweep%0d_r_%0d_%0d", i, ra, rb), r8, ra % rb);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
